// File: rtl/fwd_pkg.sv
// Shared definitions for the packet forwarder: FSM encoding, skid depth and
// the length-width helper.
package fwd_pkg;

    // Two words of skid storage: enough for one word in flight from the
    // read port plus one word held against a stalled consumer.
    localparam int FWD_SKID_DEPTH = 2;
    localparam int FWD_SKID_CNT_W = $clog2(FWD_SKID_DEPTH + 1);

    // FSM encoding (plain constants so older tools can consume them)
    localparam int         FWD_ST_W    = 3;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_READ     = 3'd1;
    localparam logic [2:0] ST_FLUSH    = 3'd2;
    localparam logic [2:0] ST_RELEASE  = 3'd3;
    localparam logic [2:0] ST_COOLDOWN = 3'd4;

    // Length counts words 0..2^addr_w inclusive, so it needs one extra bit.
    function automatic int plen_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/packet_forwarder_axis_if.sv
// AXI-Stream bus between the forwarder (master) and the egress port (slave).
interface packet_forwarder_axis_if #(
    parameter int DATA_WIDTH = 64
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/packet_forwarder_axis_skid.sv
// fwd_skid_fifo: small {last,data} FIFO that decouples the fixed-latency
// read port from AXI-Stream backpressure. Push and pop in the same cycle
// are both honoured.
module fwd_skid_fifo
    import fwd_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  logic                      i_push_last,
    input  logic [DATA_WIDTH-1:0]     i_push_data,
    input  logic                      i_pop,
    output logic                      o_head_last,
    output logic [DATA_WIDTH-1:0]     o_head_data,
    output logic [FWD_SKID_CNT_W-1:0] o_count,
    output logic                      o_full,
    output logic                      o_empty
);
    localparam int PTR_W = $clog2(FWD_SKID_DEPTH);

    logic [DATA_WIDTH-1:0]     r_data [FWD_SKID_DEPTH];
    logic [FWD_SKID_DEPTH-1:0] r_last;
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [FWD_SKID_CNT_W-1:0] r_count;

    // Storage and write pointer; depth is a power of two so pointers wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FWD_SKID_DEPTH; i++) r_data[i] <= '0;
            r_last   <= '0;
            r_wr_ptr <= '0;
        end else if (i_push) begin
            r_data[r_wr_ptr] <= i_push_data;
            r_last[r_wr_ptr] <= i_push_last;
            r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
        end
    end

    // Read pointer and occupancy; simultaneous push/pop leaves count alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + FWD_SKID_CNT_W'(1);
                2'b01:   r_count <= r_count - FWD_SKID_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_data = r_data[r_rd_ptr];
    assign o_head_last = r_last[r_rd_ptr];
    assign o_count     = r_count;
    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == FWD_SKID_CNT_W'(FWD_SKID_DEPTH));

endmodule

// File: rtl/packet_forwarder_axis.sv
// packet_forwarder_axis: reads an accepted packet out of the filter-array
// buffer and streams it as one AXI-Stream packet, then releases the buffer.
// Optional build macro FWD_STATS_EN adds packet and beat counters.
module packet_forwarder_axis
    import fwd_pkg::*;
#(
    parameter int SNOOP_FWD_ADDR_WIDTH = 9,
    parameter int DATA_WIDTH           = 64,
    parameter int PLEN_WIDTH           = plen_w(SNOOP_FWD_ADDR_WIDTH)
) (
    input  logic                            axi_aclk,
    input  logic                            rst,
    input  logic                            i_ready_for_forwarder,
    input  logic [PLEN_WIDTH-1:0]           i_len_to_forwarder,
    output logic [SNOOP_FWD_ADDR_WIDTH-1:0] o_forwarder_rd_addr,
    output logic                            o_forwarder_rd_en,
    input  logic [DATA_WIDTH-1:0]           i_forwarder_rd_data,
    output logic                            o_forwarder_done,
    packet_forwarder_axis_if.master         m_axis
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]                     o_pkt_count,
    output logic [31:0]                     o_beat_count
`endif
);
    localparam logic [PLEN_WIDTH-1:0] LEN_MAX = PLEN_WIDTH'(1) << SNOOP_FWD_ADDR_WIDTH;
    localparam int                    OCC_W   = FWD_SKID_CNT_W + 1;

    logic [FWD_ST_W-1:0]             r_state;
    logic [PLEN_WIDTH-1:0]           r_len_q;
    logic [SNOOP_FWD_ADDR_WIDTH-1:0] r_addr;
    logic [SNOOP_FWD_ADDR_WIDTH-1:0] r_addr_hold;
    logic                            r_rd_en_q;
    logic                            r_last_q;

    logic                      w_rd_en;
    logic                      w_is_last_addr;
    logic [PLEN_WIDTH-1:0]     w_len_sat;
    logic [OCC_W-1:0]          w_occupancy;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_head_last;
    logic [DATA_WIDTH-1:0]     w_head_data;
    logic [FWD_SKID_CNT_W-1:0] w_fifo_count;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic                      w_handshake;

    // Oversized lengths are clamped to the buffer size
    assign w_len_sat      = (i_len_to_forwarder > LEN_MAX) ? LEN_MAX : i_len_to_forwarder;
    // Words held plus the word still coming back from the read port
    assign w_occupancy    = OCC_W'(w_fifo_count) + OCC_W'(r_rd_en_q);
    assign w_rd_en        = (r_state == ST_READ) && (w_occupancy < OCC_W'(FWD_SKID_DEPTH));
    assign w_is_last_addr = (PLEN_WIDTH'(r_addr) == (r_len_q - PLEN_WIDTH'(1)));

    // Packet sequencing: accept, fetch, wait for last word, release, cool down
    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_len_q <= '0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_ready_for_forwarder) begin
                        r_len_q <= w_len_sat;
                        r_addr  <= '0;
                        r_state <= (w_len_sat == '0) ? ST_RELEASE : ST_READ;
                    end
                end
                ST_READ: begin
                    if (w_rd_en) begin
                        r_addr <= r_addr + SNOOP_FWD_ADDR_WIDTH'(1);
                        if (w_is_last_addr) r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH:    r_state <= ST_RELEASE;
                ST_RELEASE:  r_state <= ST_COOLDOWN;
                // Tree's ready is registered, so it is still high here
                ST_COOLDOWN: r_state <= ST_IDLE;
                default:     r_state <= ST_IDLE;
            endcase
        end
    end

    // Track the word in flight from the read port and its last tag
    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) begin
            r_rd_en_q   <= 1'b0;
            r_last_q    <= 1'b0;
            r_addr_hold <= '0;
        end else begin
            r_rd_en_q <= w_rd_en;
            r_last_q  <= w_rd_en && w_is_last_addr;
            if (w_rd_en) r_addr_hold <= r_addr;
        end
    end

    assign o_forwarder_rd_en   = w_rd_en;
    assign o_forwarder_rd_addr = w_rd_en ? r_addr : r_addr_hold;
    assign o_forwarder_done    = (r_state == ST_RELEASE);

    // Arriving words bypass the FIFO when it is empty; a bypassed word that
    // is not accepted is pushed so it is presented again unchanged.
    assign m_axis.tvalid = r_rd_en_q || !w_fifo_empty;
    assign m_axis.tdata  = !w_fifo_empty ? w_head_data :
                           (r_rd_en_q ? i_forwarder_rd_data : '0);
    assign m_axis.tlast  = !w_fifo_empty ? w_head_last : (r_rd_en_q && r_last_q);
    assign w_handshake   = m_axis.tvalid && m_axis.tready;
    assign w_pop         = !w_fifo_empty && m_axis.tready;
    assign w_push        = r_rd_en_q && !(w_fifo_empty && m_axis.tready);

    fwd_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (axi_aclk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_last (r_last_q),
        .i_push_data (i_forwarder_rd_data),
        .i_pop       (w_pop),
        .o_head_last (w_head_last),
        .o_head_data (w_head_data),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // The read credit must make a push into a full skid buffer impossible
    a_skid_no_overflow: assert property (
        @(posedge axi_aclk) disable iff (rst) !(w_push && w_fifo_full));

`ifdef FWD_STATS_EN
    logic [31:0] r_pkt_count;
    logic [31:0] r_beat_count;

    // Packets released with at least one word, and accepted beats; both wrap
    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) begin
            r_pkt_count  <= '0;
            r_beat_count <= '0;
        end else begin
            if ((r_state == ST_RELEASE) && (r_len_q != '0)) r_pkt_count <= r_pkt_count + 32'd1;
            if (w_handshake) r_beat_count <= r_beat_count + 32'd1;
        end
    end

    assign o_pkt_count  = r_pkt_count;
    assign o_beat_count = r_beat_count;
`endif

endmodule
